// File: rtl/text_scroller_pkg.sv
// Shared constants and types for the scrolling text display controller.
// Glyph codes, blank column value and display state encoding live here.
package text_scroller_pkg;

  localparam int MODE_GLYPH = 6;
  localparam logic [7:0] BLANK_COL = 8'h00;

  typedef logic [5:0] glyph_code_t;

  localparam glyph_code_t CODE_SPACE = 6'h00;
  localparam glyph_code_t CODE_ZERO  = 6'h20;
  localparam glyph_code_t CODE_A     = 6'h21;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SHOW_GLYPH,
    ST_SHOW_RAW
  } disp_state_t;

endpackage

// File: rtl/text_scroller_font_rom.sv
// Combinational 6-bit-code by 8-column glyph table.
// Column 0 and all undefined codes/columns are blank for inter-glyph spacing.
module font_rom_6x8
  import text_scroller_pkg::*;
(
  input  glyph_code_t code,
  input  logic [2:0]  col,
  output logic [7:0]  col_data
);

  always_comb begin
    col_data = BLANK_COL;
    case (code)
      CODE_ZERO: begin
        case (col)
          3'd1: col_data = 8'h3E;
          3'd2: col_data = 8'h61;
          3'd3: col_data = 8'h51;
          3'd4: col_data = 8'h49;
          3'd5: col_data = 8'h45;
          3'd6: col_data = 8'h3E;
          default: col_data = BLANK_COL;
        endcase
      end
      CODE_A: begin
        case (col)
          3'd1: col_data = 8'h7C;
          3'd2: col_data = 8'h12;
          3'd3: col_data = 8'h11;
          3'd4: col_data = 8'h11;
          3'd5: col_data = 8'h12;
          3'd6: col_data = 8'h7C;
          default: col_data = BLANK_COL;
        endcase
      end
      CODE_SPACE: col_data = BLANK_COL;
      default:    col_data = BLANK_COL;
    endcase
  end

endmodule

// File: rtl/text_scroller.sv
// Character ring buffer with prescaled column scrolling toward an LED column driver.
// state         | meaning
// ST_EMPTY      | no stored characters, output blank
// ST_SHOW_GLYPH | current char is a font glyph, col walks its columns
// ST_SHOW_RAW   | current char is a single raw column with edge bits
module text_scroller
  import text_scroller_pkg::*;
#(
  parameter int WORD_COUNT = 28,
  parameter int CHAR_BITS  = MODE_GLYPH + 1,
  parameter int GLYPH_COLS = 8,
  parameter int PRESCALE_W = 16,
  localparam int COL_W = (GLYPH_COLS > 1) ? $clog2(GLYPH_COLS) : 1,
  localparam int CNT_W = $clog2(WORD_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_valid,
  input  logic [CHAR_BITS-1:0]  wr_data,
  output logic                  wr_ready,
  input  logic                  scroll_en,
  input  logic [PRESCALE_W-1:0] scroll_div,
  input  logic                  under,
  input  logic                  over,
  output logic [7:0]            col_out,
  output logic [COL_W-1:0]      col_idx,
  output logic                  char_strobe,
  output logic [CNT_W-1:0]      fill_level
);

  localparam int PTR_W = $clog2(WORD_COUNT);
  localparam int SUM_W = CNT_W + 1;

  logic [CHAR_BITS-1:0]  mem [WORD_COUNT];
  logic [PTR_W-1:0]      wr_ptr, rd_base, disp_ptr, disp_nxt, disp_inc, disp_adv, end_ptr, wr_inc;
  logic [SUM_W-1:0]      end_sum;
  logic [CNT_W-1:0]      count;
  logic [COL_W-1:0]      col, col_nxt;
  logic [PRESCALE_W-1:0] prescaler;
  logic                  tick, strobe_nxt, wr_fire;
  logic [CHAR_BITS-1:0]  cur_char;
  glyph_code_t           cur_code;
  logic [2:0]            rom_col;
  logic [7:0]            glyph_data, col_data;
  disp_state_t           state;

  assign wr_ready   = (count != CNT_W'(WORD_COUNT));
  assign wr_fire    = wr_valid && wr_ready;
  assign fill_level = count;
  assign col_idx    = col;
  assign tick       = scroll_en && (prescaler == scroll_div);

  assign cur_char = mem[disp_ptr];
  assign cur_code = cur_char[5:0];
  assign rom_col  = 3'(col);

  font_rom_6x8 u_font (
    .code     (cur_code),
    .col      (rom_col),
    .col_data (glyph_data)
  );

  // Logical end of the stored text, modulo the ring depth.
  assign end_sum  = SUM_W'(rd_base) + SUM_W'(count);
  assign end_ptr  = (end_sum >= SUM_W'(WORD_COUNT)) ? PTR_W'(end_sum - SUM_W'(WORD_COUNT))
                                                    : PTR_W'(end_sum);
  assign disp_inc = (disp_ptr == PTR_W'(WORD_COUNT - 1)) ? '0 : disp_ptr + 1'b1;
  assign disp_adv = (disp_inc == end_ptr) ? rd_base : disp_inc;
  assign wr_inc   = (wr_ptr == PTR_W'(WORD_COUNT - 1)) ? '0 : wr_ptr + 1'b1;

  always_comb begin
    state = ST_EMPTY;
    if (count != '0) begin
      state = cur_char[CHAR_BITS-1] ? ST_SHOW_GLYPH : ST_SHOW_RAW;
    end
  end

  always_comb begin
    col_nxt    = col;
    disp_nxt   = disp_ptr;
    strobe_nxt = 1'b0;
    col_data   = BLANK_COL;
    case (state)
      ST_SHOW_GLYPH: begin
        col_data = glyph_data;
        if (tick) begin
          if (col == COL_W'(GLYPH_COLS - 1)) begin
            col_nxt    = '0;
            disp_nxt   = disp_adv;
            strobe_nxt = 1'b1;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      ST_SHOW_RAW: begin
        col_data = {under, cur_code, over};
        col_nxt  = '0;
        if (tick) begin
          disp_nxt   = disp_adv;
          strobe_nxt = 1'b1;
        end
      end
      default: begin
        col_nxt  = '0;
        disp_nxt = disp_ptr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear && wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr      <= '0;
      rd_base     <= '0;
      disp_ptr    <= '0;
      count       <= '0;
      col         <= '0;
      prescaler   <= '0;
      col_out     <= BLANK_COL;
      char_strobe <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_inc;
        count  <= count + 1'b1;
      end
      // Past a lowered divider the count runs on to natural overflow.
      if (scroll_en) begin
        prescaler <= (prescaler == scroll_div) ? '0 : prescaler + 1'b1;
      end
      col         <= col_nxt;
      disp_ptr    <= disp_nxt;
      col_out     <= col_data;
      char_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_text_scroller.sv
// Randomized plus directed bench for text_scroller with a queue-based text model.
// Driver pushes per-cycle expectations; an independent monitor pops and compares.
module tb_text_scroller;

  localparam int WC = 28;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_data = '0;
  logic        wr_ready;
  logic        scroll_en = 1'b0;
  logic [15:0] scroll_div = '0;
  logic        under = 1'b0;
  logic        over = 1'b0;
  logic [7:0]  col_out;
  logic [2:0]  col_idx;
  logic        char_strobe;
  logic [4:0]  fill_level;

  text_scroller dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .scroll_en   (scroll_en),
    .scroll_div  (scroll_div),
    .under       (under),
    .over        (over),
    .col_out     (col_out),
    .col_idx     (col_idx),
    .char_strobe (char_strobe),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int col_out;
    int strobe;
    int fill;
    int ready;
    int col_idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] m_buf[$];
  int         m_pos = 0;
  int         m_col = 0;
  int         m_pre = 0;
  int         checks = 0;
  int         failures = 0;

  function automatic int font(input logic [5:0] code, input int c);
    int v;
    v = 0;
    if (code == 6'h20) begin
      case (c)
        1: v = 'h3E; 2: v = 'h61; 3: v = 'h51;
        4: v = 'h49; 5: v = 'h45; 6: v = 'h3E;
        default: v = 0;
      endcase
    end else if (code == 6'h21) begin
      case (c)
        1: v = 'h7C; 2: v = 'h12; 3: v = 'h11;
        4: v = 'h11; 5: v = 'h12; 6: v = 'h7C;
        default: v = 0;
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // One clock of stimulus; the model predicts what is visible after the next edge.
  task automatic step(input logic r, input logic c, input logic wv, input logic [6:0] wd,
                      input logic en, input logic [15:0] div, input logic un, input logic ov);
    exp_t e;
    logic [6:0] ch;
    int sz;
    @(negedge clk);
    reset = r; clear = c; wr_valid = wv; wr_data = wd;
    scroll_en = en; scroll_div = div; under = un; over = ov;
    sz = m_buf.size();
    e.col_out = 0;
    e.strobe  = 0;
    if (!r && !c && sz > 0) begin
      ch = m_buf[m_pos];
      if (ch[6]) e.col_out = font(ch[5:0], m_col);
      else       e.col_out = {un, ch[5:0], ov};
    end
    if (r || c) begin
      m_buf.delete();
      m_pos = 0; m_col = 0; m_pre = 0;
    end else begin
      if (sz > 0 && en && m_pre == int'(div)) begin
        ch = m_buf[m_pos];
        if (ch[6] && m_col != 7) begin
          m_col++;
        end else begin
          m_col = 0;
          m_pos = (m_pos + 1) % sz;
          e.strobe = 1;
        end
      end
      if (en) m_pre = (m_pre == int'(div)) ? 0 : (m_pre + 1) % 65536;
      if (wv && sz < WC) m_buf.push_back(wd);
    end
    e.fill    = m_buf.size();
    e.ready   = (m_buf.size() != WC) ? 1 : 0;
    e.col_idx = m_col;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("col_out",     int'(col_out),     e.col_out);
        chk("char_strobe", int'(char_strobe), e.strobe);
        chk("fill_level",  int'(fill_level),  e.fill);
        chk("wr_ready",    int'(wr_ready),    e.ready);
        chk("col_idx",     int'(col_idx),     e.col_idx);
      end
    end
  end

  initial begin : driver
    logic [15:0] div;
    // Reset, then idle scrolling with an empty buffer.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0, 0, 0);

    // Single glyph A looping.
    step(0, 0, 1, 7'h61, 0, 0, 0, 0);
    for (int i = 0; i < 26; i++) step(0, 0, 0, 0, 1, 0, 0, 0);

    // Raw column then digit zero.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 7'h15, 0, 0, 1, 0);
    step(0, 0, 1, 7'h60, 0, 0, 1, 0);
    for (int i = 0; i < 22; i++) step(0, 0, 0, 0, 1, 0, 1, 0);

    // Fill to capacity, overflow write, then clear racing a write.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < WC + 1; i++) step(0, 0, 1, 7'($urandom), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 1, 7'h61, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);

    // Divided rate, then a frozen window.
    step(0, 0, 1, 7'h61, 0, 3, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 3, 0, 0);
    for (int i = 0; i < 8; i++)  step(0, 0, 0, 0, 1, 3, 0, 0);

    // Lower the divider below the running count: no early tick.
    while (m_pre != 2) step(0, 0, 0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    // Reset mid-glyph at column 4, then restart.
    step(0, 0, 1, 7'h60, 0, 0, 0, 0);
    for (int i = 0; i < 40 && m_col != 4; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 7'h61, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 0, 0);

    // Randomized traffic; divider only changes on a prescaler wrap.
    div = 16'd1;
    for (int i = 0; i < 2000; i++) begin
      if (m_pre == 0 && $urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 3));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) == 0),
           {1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? 6'h20 + 6'($urandom_range(0, 1))
                                                                  : 6'($urandom)},
           ($urandom_range(0, 3) != 0), div,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
